// File: rtl/stage_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB stage sequencer with memory ready handshakes,
// bus-timeout detection, HALT handling and a retired-instruction counter.
module stage_sequencer #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             IM_RDY,
    input  logic             DM_RDY,
    input  logic             MEM_RD,
    input  logic             MEM_WR,
    input  logic             RB_WR,
    input  logic             HALT_REQ,
    output logic [2:0]       STAGE,
    output logic             IM_REQ,
    output logic             W_IR,
    output logic             DM_REQ,
    output logic             DM_WE,
    output logic             W_RB,
    output logic             W_PC,
    output logic             BUS_ERR,
    output logic [CNT_W-1:0] INSTR_CNT
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    localparam int             WCW       = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

    logic [2:0]       stage_q,   stage_d;
    logic [WCW-1:0]   waitCnt_q, waitCnt_d;
    logic             memRd_q,   memRd_d;
    logic             memWr_q,   memWr_d;
    logic             rbWr_q,    rbWr_d;
    logic             busErr_q,  busErr_d;
    logic             imReq_q,   imReq_d;
    logic             wIr_q,     wIr_d;
    logic             dmReq_q,   dmReq_d;
    logic             dmWe_q,    dmWe_d;
    logic             wRb_q,     wRb_d;
    logic             wPc_q,     wPc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             haltRetire;

    always_comb begin
        stage_d    = stage_q;
        memRd_d    = memRd_q;
        memWr_d    = memWr_q;
        rbWr_d     = rbWr_q;
        busErr_d   = busErr_q;
        wIr_d      = 1'b0;
        haltRetire = 1'b0;

        case (stage_q)
            S_IDLE: begin
                if (START) begin
                    stage_d = S_IF;
                end
            end
            S_IF: begin
                // A ready on the last allowed wait cycle takes priority over the timeout.
                if (IM_RDY) begin
                    stage_d = S_ID;
                    wIr_d   = 1'b1;
                end else if (waitCnt_q == WAIT_LAST) begin
                    stage_d  = S_HALT;
                    busErr_d = 1'b1;
                end
            end
            S_ID: begin
                memRd_d = MEM_RD;
                memWr_d = MEM_WR;
                rbWr_d  = RB_WR;
                if (HALT_REQ) begin
                    stage_d    = S_HALT;
                    haltRetire = 1'b1;
                end else begin
                    stage_d = S_EX;
                end
            end
            S_EX: begin
                stage_d = (memRd_q || memWr_q) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (DM_RDY) begin
                    stage_d = S_WB;
                end else if (waitCnt_q == WAIT_LAST) begin
                    stage_d  = S_HALT;
                    busErr_d = 1'b1;
                end
            end
            S_WB: begin
                stage_d = S_IF;
            end
            S_HALT: begin
                if (START) begin
                    stage_d  = S_IF;
                    busErr_d = 1'b0;
                end
            end
            default: begin
                stage_d = S_IDLE;
            end
        endcase
    end

    // The wait counter only runs while a memory handshake is pending.
    always_comb begin
        waitCnt_d = '0;
        if ((stage_d == stage_q) && ((stage_q == S_IF) || (stage_q == S_MEM))) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they line up with STAGE once registered.
    always_comb begin
        imReq_d = (stage_d == S_IF);
        dmReq_d = (stage_d == S_MEM);
        dmWe_d  = (stage_d == S_MEM) && memWr_q;
        wRb_d   = (stage_d == S_WB) && rbWr_q && !memWr_q;
        wPc_d   = (stage_d == S_WB) || haltRetire;
        cnt_d   = wPc_d ? (cnt_q + 1'b1) : cnt_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stage_q   <= S_IDLE;
            waitCnt_q <= '0;
            memRd_q   <= 1'b0;
            memWr_q   <= 1'b0;
            rbWr_q    <= 1'b0;
            busErr_q  <= 1'b0;
            imReq_q   <= 1'b0;
            wIr_q     <= 1'b0;
            dmReq_q   <= 1'b0;
            dmWe_q    <= 1'b0;
            wRb_q     <= 1'b0;
            wPc_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            stage_q   <= stage_d;
            waitCnt_q <= waitCnt_d;
            memRd_q   <= memRd_d;
            memWr_q   <= memWr_d;
            rbWr_q    <= rbWr_d;
            busErr_q  <= busErr_d;
            imReq_q   <= imReq_d;
            wIr_q     <= wIr_d;
            dmReq_q   <= dmReq_d;
            dmWe_q    <= dmWe_d;
            wRb_q     <= wRb_d;
            wPc_q     <= wPc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign STAGE     = stage_q;
    assign IM_REQ    = imReq_q;
    assign W_IR      = wIr_q;
    assign DM_REQ    = dmReq_q;
    assign DM_WE     = dmWe_q;
    assign W_RB      = wRb_q;
    assign W_PC      = wPc_q;
    assign BUS_ERR   = busErr_q;
    assign INSTR_CNT = cnt_q;

endmodule
